// File: rtl/frog_hop_ctrl_if.sv
// Bus between the keyboard/collision side and the frog motion controller.
// The master drives keycode/hit; the controller (slave) drives position, status and score.
interface frog_hop_ctrl_if #(
    parameter int unsigned SCORE_DIGITS = 3
);
    logic [15:0]               keycode;
    logic                      hit;
    logic [9:0]                pos_x;
    logic [9:0]                pos_y;
    logic [9:0]                size;
    logic                      hopping;
    logic                      dead;
    logic                      game_over;
    logic [3:0]                lives;
    logic [4*SCORE_DIGITS-1:0] score_bcd;

    modport master (
        output keycode, hit,
        input  pos_x, pos_y, size, hopping, dead, game_over, lives, score_bcd
    );

    modport slave (
        input  keycode, hit,
        output pos_x, pos_y, size, hopping, dead, game_over, lives, score_bcd
    );
endinterface

// File: rtl/frog_hop_ctrl.sv
// Frogger player motion, death/respawn and BCD scoring controller, one update per frame.
// Optional macro HOP_QUEUE_EN adds a one-entry buffer for direction presses made mid-hop.
module frog_hop_ctrl #(
    parameter int unsigned START_X        = 320,
    parameter int unsigned START_Y        = 419,
    parameter int unsigned X_MIN          = 8,
    parameter int unsigned X_MAX          = 631,
    parameter int unsigned Y_MIN          = 50,
    parameter int unsigned Y_MAX          = 430,
    parameter int unsigned STEP           = 2,
    parameter int unsigned HOP_FRAMES     = 8,
    parameter int unsigned SIZE           = 8,
    parameter int unsigned SCORE_DIGITS   = 3,
    parameter int unsigned LIVES          = 3,
    parameter int unsigned RESPAWN_FRAMES = 30,
    parameter logic [15:0] KEY_UP         = 16'h001A,
    parameter logic [15:0] KEY_LEFT       = 16'h0004,
    parameter logic [15:0] KEY_DOWN       = 16'h0016,
    parameter logic [15:0] KEY_RIGHT      = 16'h0007
) (
    input logic            frame_clk,
    input logic            Reset_n,
    frog_hop_ctrl_if.slave bus
);
    localparam logic [1:0] IDLE = 2'd0, HOP = 2'd1, DEAD = 2'd2, OVER = 2'd3;
    localparam logic [1:0] DIR_UP = 2'd0, DIR_LEFT = 2'd1, DIR_DOWN = 2'd2, DIR_RIGHT = 2'd3;

    localparam int unsigned SW  = 4 * SCORE_DIGITS;
    localparam int unsigned HCW = $clog2(HOP_FRAMES + 1);
    localparam int unsigned DCW = $clog2(RESPAWN_FRAMES + 1);
    localparam logic [HCW-1:0] HOP_LAST  = HCW'(HOP_FRAMES - 1);
    localparam logic [DCW-1:0] DEAD_LAST = DCW'(RESPAWN_FRAMES - 1);
    localparam logic [10:0] HOP_DIST = 11'(STEP * HOP_FRAMES);
    localparam logic [10:0] X_MIN_W = 11'(X_MIN), X_MAX_W = 11'(X_MAX);
    localparam logic [10:0] Y_MIN_W = 11'(Y_MIN), Y_MAX_W = 11'(Y_MAX);
    localparam logic [9:0]  STEP_W = 10'(STEP), START_X_W = 10'(START_X), START_Y_W = 10'(START_Y);
    localparam logic [3:0]  LIVES_W = 4'(LIVES);

    logic [1:0]     r_state;
    logic [9:0]     r_pos_x, r_pos_y, r_best_y;
    logic [SW-1:0]  r_score;
    logic [3:0]     r_lives;
    logic [15:0]    r_prev_key;
    logic [1:0]     r_dir;
    logic [HCW-1:0] r_hop_cnt;
    logic [DCW-1:0] r_dead_cnt;

    logic           w_is_key, w_press;
    logic [1:0]     w_key_dir;
    logic [9:0]     w_next_x, w_next_y;

    // Bounds check done one bit wider so an underflowing subtraction reads as out of range.
    function automatic logic target_ok(input logic [1:0] dir, input logic [9:0] x, input logic [9:0] y);
        logic [10:0] cx, cy;
        logic        ok;
        cx = {1'b0, x};
        cy = {1'b0, y};
        ok = 1'b0;
        case (dir)
            DIR_UP:    ok = (cy >= HOP_DIST) && (cy - HOP_DIST >= Y_MIN_W) && (cy - HOP_DIST <= Y_MAX_W);
            DIR_DOWN:  ok = (cy + HOP_DIST >= Y_MIN_W) && (cy + HOP_DIST <= Y_MAX_W);
            DIR_LEFT:  ok = (cx >= HOP_DIST) && (cx - HOP_DIST >= X_MIN_W) && (cx - HOP_DIST <= X_MAX_W);
            default:   ok = (cx + HOP_DIST >= X_MIN_W) && (cx + HOP_DIST <= X_MAX_W);
        endcase
        return ok;
    endfunction

    // A carry out of the top digit means every digit was 9, so the score stays saturated.
    function automatic logic [SW-1:0] bcd_inc(input logic [SW-1:0] s);
        logic [SW-1:0] r;
        logic          carry;
        r = s;
        carry = 1'b1;
        for (int i = 0; i < SCORE_DIGITS; i++) begin
            if (carry) begin
                if (r[4*i +: 4] == 4'd9) begin
                    r[4*i +: 4] = 4'd0;
                end else begin
                    r[4*i +: 4] = r[4*i +: 4] + 4'd1;
                    carry = 1'b0;
                end
            end
        end
        return carry ? s : r;
    endfunction

    always_comb begin
        w_is_key  = 1'b1;
        w_key_dir = DIR_UP;
        case (bus.keycode)
            KEY_UP:    w_key_dir = DIR_UP;
            KEY_LEFT:  w_key_dir = DIR_LEFT;
            KEY_DOWN:  w_key_dir = DIR_DOWN;
            KEY_RIGHT: w_key_dir = DIR_RIGHT;
            default:   w_is_key = 1'b0;
        endcase
    end

    assign w_press = w_is_key && (bus.keycode != r_prev_key);

    always_comb begin
        w_next_x = r_pos_x;
        w_next_y = r_pos_y;
        case (r_dir)
            DIR_UP:    w_next_y = r_pos_y - STEP_W;
            DIR_DOWN:  w_next_y = r_pos_y + STEP_W;
            DIR_LEFT:  w_next_x = r_pos_x - STEP_W;
            default:   w_next_x = r_pos_x + STEP_W;
        endcase
    end

`ifdef HOP_QUEUE_EN
    logic       r_q_valid;
    logic [1:0] r_q_dir;
    logic       w_q_valid;
    logic [1:0] w_q_dir;

    assign w_q_valid = w_press | r_q_valid;
    assign w_q_dir   = w_press ? w_key_dir : r_q_dir;
`endif

    always_ff @(posedge frame_clk or negedge Reset_n) begin
        if (!Reset_n) begin
            r_state    <= IDLE;
            r_pos_x    <= START_X_W;
            r_pos_y    <= START_Y_W;
            r_best_y   <= START_Y_W;
            r_score    <= '0;
            r_lives    <= LIVES_W;
            r_prev_key <= '0;
            r_dir      <= DIR_UP;
            r_hop_cnt  <= '0;
            r_dead_cnt <= '0;
`ifdef HOP_QUEUE_EN
            r_q_valid  <= 1'b0;
            r_q_dir    <= DIR_UP;
`endif
        end else begin
            r_prev_key <= bus.keycode;
            case (r_state)
                IDLE, HOP: begin
                    if (bus.hit) begin
`ifdef HOP_QUEUE_EN
                        r_q_valid <= 1'b0;
`endif
                        if (r_lives > 4'd1) begin
                            r_lives    <= r_lives - 4'd1;
                            r_dead_cnt <= '0;
                            r_state    <= DEAD;
                        end else begin
                            r_lives <= 4'd0;
                            r_state <= OVER;
                        end
                    end else if (r_state == IDLE) begin
                        if (w_press && target_ok(w_key_dir, r_pos_x, r_pos_y)) begin
                            r_dir     <= w_key_dir;
                            r_hop_cnt <= '0;
                            r_state   <= HOP;
                        end
                    end else begin
                        r_pos_x   <= w_next_x;
                        r_pos_y   <= w_next_y;
                        r_hop_cnt <= r_hop_cnt + HCW'(1);
`ifdef HOP_QUEUE_EN
                        if (w_press) begin
                            r_q_valid <= 1'b1;
                            r_q_dir   <= w_key_dir;
                        end
`endif
                        if (r_hop_cnt == HOP_LAST) begin
                            if (w_next_y < r_best_y) begin
                                r_best_y <= w_next_y;
                                r_score  <= bcd_inc(r_score);
                            end
`ifdef HOP_QUEUE_EN
                            r_q_valid <= 1'b0;
                            if (w_q_valid && target_ok(w_q_dir, w_next_x, w_next_y)) begin
                                r_dir     <= w_q_dir;
                                r_hop_cnt <= '0;
                            end else begin
                                r_state <= IDLE;
                            end
`else
                            r_state <= IDLE;
`endif
                        end
                    end
                end
                DEAD: begin
                    if (r_dead_cnt == DEAD_LAST) begin
                        r_pos_x  <= START_X_W;
                        r_pos_y  <= START_Y_W;
                        r_best_y <= START_Y_W;
                        r_state  <= IDLE;
                    end else begin
                        r_dead_cnt <= r_dead_cnt + DCW'(1);
                    end
                end
                default: begin
                end
            endcase
        end
    end

    assign bus.pos_x     = r_pos_x;
    assign bus.pos_y     = r_pos_y;
    assign bus.size      = 10'(SIZE);
    assign bus.hopping   = (r_state == HOP);
    assign bus.dead      = (r_state == DEAD);
    assign bus.game_over = (r_state == OVER);
    assign bus.lives     = r_lives;
    assign bus.score_bcd = r_score;
endmodule

// File: tb/tb_frog_hop_ctrl.sv
// Self-checking bench for frog_hop_ctrl: vector table, directed corner sequences and
// randomized key/hit traffic compared against a position/target-based reference model.
module tb_frog_hop_ctrl;
    localparam logic [15:0] KEY_UP = 16'h001A, KEY_LEFT = 16'h0004;
    localparam logic [15:0] KEY_DOWN = 16'h0016, KEY_RIGHT = 16'h0007;

    logic frame_clk = 1'b0;
    logic Reset_n;

    frog_hop_ctrl_if #(.SCORE_DIGITS(3)) bus ();
    frog_hop_ctrl_if #(.SCORE_DIGITS(1)) busSat ();

    frog_hop_ctrl u_dut (.frame_clk(frame_clk), .Reset_n(Reset_n), .bus(bus));
    frog_hop_ctrl #(.SCORE_DIGITS(1)) u_sat (.frame_clk(frame_clk), .Reset_n(Reset_n), .bus(busSat));

    always #5 frame_clk = ~frame_clk;

    int checks = 0;
    int errors = 0;

    // Reference model: position is derived from the hop target and frames still to go.
    int mX, mY, mBest, mScore, mSatScore, mLives, mMode, mRemain, mTx, mTy, mDx, mDy, mDeadLeft;
    logic [15:0] mPrev;
    int mQ;
    logic [15:0] mQKey;

    typedef struct {
        logic [15:0] key;
        logic        hit;
        int          frames;
        int          expX;
        int          expY;
        logic        expHop;
        logic [11:0] expScore;
        int          expLives;
    } vec_t;

    vec_t vecs[10];

    function automatic logic isKey(input logic [15:0] k);
        return (k == KEY_UP) || (k == KEY_LEFT) || (k == KEY_DOWN) || (k == KEY_RIGHT);
    endfunction

    function automatic logic [11:0] toBcd(input int v);
        return {4'(v / 100 % 10), 4'(v / 10 % 10), 4'(v % 10)};
    endfunction

    task modelReset();
        mX = 320; mY = 419; mBest = 419; mScore = 0; mSatScore = 0;
        mLives = 3; mMode = 0; mRemain = 0; mPrev = 16'h0; mQ = 0; mQKey = 16'h0;
        mTx = 320; mTy = 419; mDx = 0; mDy = 0; mDeadLeft = 0;
    endtask

    task startHop(input logic [15:0] key);
        int dx, dy, tx, ty;
        dx = (key == KEY_RIGHT) ? 1 : (key == KEY_LEFT) ? -1 : 0;
        dy = (key == KEY_DOWN) ? 1 : (key == KEY_UP) ? -1 : 0;
        tx = mX + 16 * dx;
        ty = mY + 16 * dy;
        if (tx >= 8 && tx <= 631 && ty >= 50 && ty <= 430) begin
            mMode = 1; mRemain = 8; mTx = tx; mTy = ty; mDx = dx; mDy = dy;
        end
    endtask

    task modelStep(input logic [15:0] key, input logic hit);
        logic press;
        press = isKey(key) && (key != mPrev);
        mPrev = key;
        if ((mMode == 0 || mMode == 1) && hit) begin
            mQ = 0;
            if (mLives > 1) begin
                mLives = mLives - 1; mMode = 2; mDeadLeft = 30;
            end else begin
                mLives = 0; mMode = 3;
            end
        end else if (mMode == 0) begin
            if (press) startHop(key);
        end else if (mMode == 1) begin
`ifdef HOP_QUEUE_EN
            if (press) begin mQ = 1; mQKey = key; end
`endif
            mRemain = mRemain - 1;
            mX = mTx - mRemain * 2 * mDx;
            mY = mTy - mRemain * 2 * mDy;
            if (mRemain == 0) begin
                mMode = 0;
                if (mY < mBest) begin
                    mBest = mY;
                    mScore = (mScore < 999) ? mScore + 1 : 999;
                    mSatScore = (mSatScore < 9) ? mSatScore + 1 : 9;
                end
                if (mQ != 0) startHop(mQKey);
                mQ = 0;
            end
        end else if (mMode == 2) begin
            mDeadLeft = mDeadLeft - 1;
            if (mDeadLeft == 0) begin
                mX = 320; mY = 419; mBest = 419; mMode = 0;
            end
        end
    endtask

    task checkOutput(input string name, input logic [63:0] actual, input logic [63:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got %0h expected %0h", name, actual, expected);
        end
    endtask

    // Inputs change 1 time unit after the edge, so they are stable at the next edge.
    task applyStimulus(input logic [15:0] key, input logic hit);
        bus.keycode = key;    bus.hit = hit;
        busSat.keycode = key; busSat.hit = hit;
        modelStep(key, hit);
        @(posedge frame_clk);
        #1;
    endtask

    task idleFrames(input int n);
        for (int f = 0; f < n; f++) applyStimulus(16'h0, 1'b0);
    endtask

    task doReset();
        bus.keycode = 16'h0;    bus.hit = 1'b0;
        busSat.keycode = 16'h0; busSat.hit = 1'b0;
        Reset_n = 1'b0;
        #2;
        Reset_n = 1'b1;
        modelReset();
    endtask

    task compareModel(input string name);
        checkOutput(name,
            64'({bus.pos_x, bus.pos_y, bus.hopping, bus.dead, bus.game_over, bus.lives, bus.score_bcd}),
            64'({10'(mX), 10'(mY), mMode == 1, mMode == 2, mMode == 3, 4'(mLives), toBcd(mScore)}));
    endtask

    initial begin
        logic [15:0] rKey;
        int sel;
        vecs[0] = '{16'h0,     1'b0, 1, 320, 419, 1'b0, 12'h000, 3};
        vecs[1] = '{KEY_UP,    1'b0, 1, 320, 419, 1'b1, 12'h000, 3};
        vecs[2] = '{16'h0,     1'b0, 4, 320, 411, 1'b1, 12'h000, 3};
        vecs[3] = '{16'h0,     1'b0, 4, 320, 403, 1'b0, 12'h001, 3};
        vecs[4] = '{KEY_DOWN,  1'b0, 9, 320, 419, 1'b0, 12'h001, 3};
        vecs[5] = '{KEY_DOWN,  1'b0, 2, 320, 419, 1'b0, 12'h001, 3};
        vecs[6] = '{KEY_UP,    1'b0, 9, 320, 403, 1'b0, 12'h001, 3};
        vecs[7] = '{KEY_LEFT,  1'b0, 9, 304, 403, 1'b0, 12'h001, 3};
        vecs[8] = '{KEY_RIGHT, 1'b0, 9, 320, 403, 1'b0, 12'h001, 3};
        vecs[9] = '{KEY_UP,    1'b0, 9, 320, 387, 1'b0, 12'h002, 3};

        Reset_n = 1'b0;
        bus.keycode = 16'h0;    bus.hit = 1'b0;
        busSat.keycode = 16'h0; busSat.hit = 1'b0;
        modelReset();
        #12;
        checkOutput("reset_state",
            64'({bus.pos_x, bus.pos_y, bus.size, bus.hopping, bus.dead, bus.game_over, bus.lives, bus.score_bcd}),
            64'({10'd320, 10'd419, 10'd8, 1'b0, 1'b0, 1'b0, 4'd3, 12'h000}));
        Reset_n = 1'b1;

        for (int i = 0; i < 10; i++) begin
            applyStimulus(vecs[i].key, vecs[i].hit);
            idleFrames(vecs[i].frames - 1);
            checkOutput($sformatf("vec%0d", i),
                64'({bus.pos_x, bus.pos_y, bus.hopping, bus.score_bcd, bus.lives}),
                64'({10'(vecs[i].expX), 10'(vecs[i].expY), vecs[i].expHop, vecs[i].expScore, 4'(vecs[i].expLives)}));
        end

        // Held key produces a single hop.
        doReset();
        for (int f = 0; f < 20; f++) applyStimulus(KEY_UP, 1'b0);
        checkOutput("held_key", 64'({bus.pos_y, bus.hopping, bus.score_bcd}), 64'({10'd403, 1'b0, 12'h001}));

        // Hit mid-hop, respawn, then lose the remaining lives.
        applyStimulus(16'h0, 1'b0);
        applyStimulus(KEY_UP, 1'b0);
        idleFrames(3);
        applyStimulus(16'h0, 1'b1);
        checkOutput("hit_freeze", 64'({bus.pos_y, bus.dead, bus.hopping, bus.lives}), 64'({10'd397, 1'b1, 1'b0, 4'd2}));
        idleFrames(29);
        checkOutput("dead_hold", 64'({bus.dead, bus.pos_y}), 64'({1'b1, 10'd397}));
        idleFrames(1);
        checkOutput("respawn", 64'({bus.dead, bus.pos_x, bus.pos_y, bus.score_bcd, bus.lives}),
                    64'({1'b0, 10'd320, 10'd419, 12'h001, 4'd2}));
        applyStimulus(16'h0, 1'b1);
        checkOutput("second_hit", 64'({bus.dead, bus.lives}), 64'({1'b1, 4'd1}));
        idleFrames(30);
        applyStimulus(16'h0, 1'b1);
        checkOutput("game_over", 64'({bus.game_over, bus.dead, bus.lives}), 64'({1'b1, 1'b0, 4'd0}));
        applyStimulus(KEY_UP, 1'b1);
        idleFrames(8);
        checkOutput("over_ignores", 64'({bus.pos_y, bus.hopping, bus.game_over, bus.lives}),
                    64'({10'd419, 1'b0, 1'b1, 4'd0}));

        // Asynchronous reset mid-hop.
        doReset();
        applyStimulus(KEY_UP, 1'b0);
        idleFrames(3);
        #2;
        Reset_n = 1'b0;
        #1;
        checkOutput("async_reset", 64'({bus.pos_y, bus.hopping, bus.lives}), 64'({10'd419, 1'b0, 4'd3}));
        Reset_n = 1'b1;
        modelReset();

        // Score counting and single-digit saturation.
        doReset();
        for (int h = 1; h <= 12; h++) begin
            applyStimulus(KEY_UP, 1'b0);
            idleFrames(8);
            checkOutput($sformatf("score3_h%0d", h), 64'(bus.score_bcd), 64'(toBcd(h)));
            checkOutput($sformatf("score1_h%0d", h), 64'(busSat.score_bcd), 64'((h < 9) ? h : 9));
        end

        // Direction press made during a hop.
        doReset();
        applyStimulus(KEY_UP, 1'b0);
        idleFrames(3);
        applyStimulus(KEY_LEFT, 1'b0);
        idleFrames(4);
`ifdef HOP_QUEUE_EN
        checkOutput("queued_no_gap", 64'({bus.hopping, bus.pos_y}), 64'({1'b1, 10'd403}));
        idleFrames(8);
        checkOutput("queued_hop", 64'({bus.hopping, bus.pos_x}), 64'({1'b0, 10'd304}));
`else
        checkOutput("midhop_gap", 64'({bus.hopping, bus.pos_y}), 64'({1'b0, 10'd403}));
        idleFrames(8);
        checkOutput("midhop_drop", 64'({bus.hopping, bus.pos_x}), 64'({1'b0, 10'd320}));
`endif

        // Randomized traffic against the reference model.
        doReset();
        rKey = 16'h0;
        for (int n = 0; n < 1500; n++) begin
            sel = $urandom_range(0, 10);
            case (sel)
                4:       rKey = 16'h0;
                5, 6:    rKey = KEY_UP;
                7:       rKey = KEY_LEFT;
                8:       rKey = KEY_DOWN;
                9:       rKey = KEY_RIGHT;
                10:      rKey = 16'h0005;
                default: rKey = rKey;
            endcase
            applyStimulus(rKey, $urandom_range(0, 59) == 0);
            compareModel("rand");
            if (mMode == 3 && $urandom_range(0, 3) == 0) doReset();
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
